// File: rtl/direction_input_ctrl_pkg.sv
// Shared snake heading encodings and helpers for the direction input path.
// The movement logic imports the same definitions.
package direction_input_ctrl_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef struct packed {
        logic       valid;
        logic [1:0] dir;
    } dir_req_t;

    // Opposite heading: flipping the top bit swaps up/down and right/left.
    function automatic logic [1:0] reverse_dir(input logic [1:0] dir);
        return dir ^ 2'b10;
    endfunction

endpackage

// File: rtl/direction_input_ctrl_button_debouncer.sv
// One push-button: 2-flop synchroniser, sample-paced stability counter,
// debounced level and a single-cycle press pulse on the accepted 0->1 flip.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic SAMPLE_TICK,
    input  logic btn_raw,
    output logic btn_level,
    output logic press
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_SAMPLES - 1);

    logic       sync1_r;
    logic       sync2_r;
    logic       level_r;
    logic [3:0] cnt_r;
    logic       differ_s;
    logic       flip_s;

    // Flip decision; press is combinational so the consumer sees it on the flip edge.
    always_comb begin
        differ_s = (sync2_r != level_r);
        flip_s   = SAMPLE_TICK && differ_s && (cnt_r == CNT_LAST);
    end

    // Synchroniser, stability counter and debounced level.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            cnt_r   <= 4'd0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            if (SAMPLE_TICK) begin
                if (!differ_s) begin
                    cnt_r <= 4'd0;
                end else if (cnt_r == CNT_LAST) begin
                    level_r <= ~level_r;
                    cnt_r   <= 4'd0;
                end else begin
                    cnt_r <= cnt_r + 4'd1;
                end
            end
        end
    end

    assign btn_level = level_r;
    assign press     = flip_s && !level_r;

endmodule

// File: rtl/direction_input_ctrl.sv
// Turns four raw buttons into a committed snake heading: debounce, priority
// select, reversal filtering against the committed heading, commit on step.
module direction_input_ctrl
    import direction_input_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SAMPLES = 4,
    parameter logic [1:0]  RESET_DIR        = 2'b01
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SAMPLE_TICK,
    input  logic       MOVE_TICK,
    input  logic       BTN_U,
    input  logic       BTN_D,
    input  logic       BTN_L,
    input  logic       BTN_R,
    output logic [1:0] DIRECTION,
    output logic       DIR_CHANGED,
    output logic [3:0] BTN_STATE
);

    logic [3:0] raw_s;
    logic [3:0] level_s;
    logic [3:0] press_s;
    dir_req_t   req_s;
    logic       accept_s;
    logic [1:0] pend_next_s;
    logic [1:0] pend_r;
    logic [1:0] dir_r;
    logic       changed_r;

    assign raw_s = {BTN_U, BTN_D, BTN_L, BTN_R};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
        ) u_deb (
            .CLK        (CLK),
            .RESET      (RESET),
            .SAMPLE_TICK(SAMPLE_TICK),
            .btn_raw    (raw_s[i]),
            .btn_level  (level_s[i]),
            .press      (press_s[i])
        );
    end

    // Priority U > D > L > R, then filter against the committed heading (not P).
    always_comb begin
        req_s = '{valid: 1'b0, dir: DIR_UP};
        if (press_s[3]) begin
            req_s = '{valid: 1'b1, dir: DIR_UP};
        end else if (press_s[2]) begin
            req_s = '{valid: 1'b1, dir: DIR_DOWN};
        end else if (press_s[1]) begin
            req_s = '{valid: 1'b1, dir: DIR_LEFT};
        end else if (press_s[0]) begin
            req_s = '{valid: 1'b1, dir: DIR_RIGHT};
        end else begin
            req_s = '{valid: 1'b0, dir: DIR_UP};
        end
        accept_s = req_s.valid && (req_s.dir != reverse_dir(dir_r));
        if (accept_s) begin
            pend_next_s = req_s.dir;
        end else begin
            pend_next_s = pend_r;
        end
    end

    // Pending request, committed heading and change pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend_r    <= RESET_DIR;
            dir_r     <= RESET_DIR;
            changed_r <= 1'b0;
        end else begin
            pend_r <= pend_next_s;
            if (MOVE_TICK) begin
                dir_r     <= pend_next_s;
                changed_r <= (pend_next_s != dir_r);
            end else begin
                changed_r <= 1'b0;
            end
        end
    end

    assign DIRECTION   = dir_r;
    assign DIR_CHANGED = changed_r;
    assign BTN_STATE   = level_s;

endmodule

// File: tb/tb_direction_input_ctrl.sv
// Directed scenarios for direction_input_ctrl with a commit scoreboard:
// each step pushes the expected {DIRECTION, DIR_CHANGED}; a monitor pops after commit.
module tb_direction_input_ctrl;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       SAMPLE_TICK = 1'b0;
    logic       MOVE_TICK = 1'b0;
    logic       BTN_U = 1'b0;
    logic       BTN_D = 1'b0;
    logic       BTN_L = 1'b0;
    logic       BTN_R = 1'b0;
    logic [1:0] DIRECTION;
    logic       DIR_CHANGED;
    logic [3:0] BTN_STATE;

    int         n_checks = 0;
    int         n_fail = 0;
    int         scnt = 0;
    logic [2:0] exp_q[$];
    logic [1:0] cur_dir = 2'b01;
    logic       mv_seen = 1'b0;

    direction_input_ctrl #(.DEBOUNCE_SAMPLES(4), .RESET_DIR(2'b01)) dut (
        .CLK(CLK), .RESET(RESET), .SAMPLE_TICK(SAMPLE_TICK), .MOVE_TICK(MOVE_TICK),
        .BTN_U(BTN_U), .BTN_D(BTN_D), .BTN_L(BTN_L), .BTN_R(BTN_R),
        .DIRECTION(DIRECTION), .DIR_CHANGED(DIR_CHANGED), .BTN_STATE(BTN_STATE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) mv_seen <= MOVE_TICK && !RESET;

    // Monitor: after a step compare against the scoreboard, otherwise the heading must hold.
    always @(negedge CLK) begin
        logic [2:0] e;
        if (mv_seen) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL commit_unexpected: got dir=%b chg=%b, no expectation queued", DIRECTION, DIR_CHANGED);
            end else begin
                e = exp_q.pop_front();
                cur_dir = e[2:1];
                if ({DIRECTION, DIR_CHANGED} !== e) begin
                    n_fail++;
                    $display("FAIL commit: got dir=%b chg=%b, expected dir=%b chg=%b",
                             DIRECTION, DIR_CHANGED, e[2:1], e[0]);
                end
            end
        end else if (!RESET) begin
            n_checks++;
            if ({DIRECTION, DIR_CHANGED} !== {cur_dir, 1'b0}) begin
                n_fail++;
                $display("FAIL idle_hold: got dir=%b chg=%b, expected dir=%b chg=0",
                         DIRECTION, DIR_CHANGED, cur_dir);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: SAMPLE_TICK every 10th cycle, optional MOVE_TICK.
    task automatic cyc(input bit mv);
        SAMPLE_TICK = (scnt == 9);
        scnt = (scnt + 1) % 10;
        MOVE_TICK = mv;
        @(posedge CLK);
        #1;
        MOVE_TICK = 1'b0;
        SAMPLE_TICK = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) cyc(1'b0);
    endtask

    task automatic do_reset(input string name);
        RESET = 1'b1;
        {BTN_U, BTN_D, BTN_L, BTN_R} = 4'b0000;
        run(3);
        chk({name, " dir"}, {6'd0, DIRECTION}, 8'h01);
        chk({name, " chg"}, {7'd0, DIR_CHANGED}, 8'h00);
        chk({name, " btn"}, {4'd0, BTN_STATE}, 8'h00);
        cur_dir = 2'b01;
        RESET = 1'b0;
    endtask

    task automatic step(input logic [1:0] d, input logic c);
        exp_q.push_back({d, c});
        cyc(1'b1);
        run(2);
    endtask

    // Clean press of mask; optionally MOVE_TICK on the cycle the press event fires.
    task automatic press(input string name, input logic [3:0] mask, input bit mv_en,
                         input logic [2:0] mv_exp);
        int q = 0;
        bit done = 1'b0;
        bit qual, mv;
        {BTN_U, BTN_D, BTN_L, BTN_R} = mask;
        for (int i = 1; i <= 100 && !done; i++) begin
            qual = (i >= 3) && (scnt == 9);
            mv = mv_en && qual && (q == 3);
            if (mv) exp_q.push_back(mv_exp);
            cyc(mv);
            if (qual) q++;
            if ((BTN_STATE & mask) == mask) done = 1'b1;
        end
        chk({name, " rise"}, {7'd0, done}, 8'h01);
        chk({name, " ticks"}, 8'(q), 8'd4);
        chk({name, " btn_state"}, {4'd0, BTN_STATE}, {4'd0, mask});
        run(3);
        {BTN_U, BTN_D, BTN_L, BTN_R} = 4'b0000;
        run(60);
        chk({name, " released"}, {4'd0, BTN_STATE}, 8'h00);
    endtask

    initial begin
        bit rose;
        int q;
        @(posedge CLK);
        #1;
        // 1. reset
        do_reset("reset");
        run(5);

        // 2. bounce rejection, then clean hold of U
        rose = 1'b0;
        for (int i = 0; i < 200; i++) begin
            BTN_U = ((i / 15) % 2 == 0);
            cyc(1'b0);
            if (BTN_STATE[3]) rose = 1'b1;
        end
        BTN_U = 1'b0;
        run(60);
        chk("bounce no_rise", {7'd0, rose}, 8'h00);
        press("bounce hold_u", 4'b1000, 1'b0, 3'b000);
        step(2'b00, 1'b1);
        step(2'b00, 1'b0);

        // 3. reversal filter
        do_reset("reset3");
        press("rev press_l", 4'b0010, 1'b0, 3'b000);
        step(2'b01, 1'b0);
        step(2'b01, 1'b0);
        step(2'b01, 1'b0);
        press("rev press_d", 4'b0100, 1'b0, 3'b000);
        step(2'b10, 1'b1);

        // 4. validation against committed heading: U accepted, L rejected
        do_reset("reset4");
        press("last press_u", 4'b1000, 1'b0, 3'b000);
        press("last press_l", 4'b0010, 1'b0, 3'b000);
        step(2'b00, 1'b1);
        press("last press_l2", 4'b0010, 1'b0, 3'b000);
        step(2'b11, 1'b1);

        // 5. simultaneous U+R press, then press coinciding with MOVE_TICK
        do_reset("reset5");
        press("simul u_r", 4'b1001, 1'b0, 3'b000);
        step(2'b00, 1'b1);
        press("simul move_l", 4'b0010, 1'b1, 3'b111);
        step(2'b11, 1'b0);

        // 6. reset while D counter is at 2 and P=10
        do_reset("reset6a");
        press("mid press_d", 4'b0100, 1'b0, 3'b000);
        BTN_D = 1'b1;
        q = 0;
        for (int i = 1; i <= 100 && q < 2; i++) begin
            if ((i >= 3) && (scnt == 9)) q++;
            cyc(1'b0);
        end
        do_reset("mid reset");
        run(5);
        step(2'b01, 1'b0);
        press("mid repress_d", 4'b0100, 1'b0, 3'b000);
        step(2'b10, 1'b1);

        run(5);
        chk("scoreboard drained", 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
